// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the three-layer inference sequencer.
package nn_seq_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 4'd0,
    L1   = 4'd1,
    L2   = 4'd2,
    L3   = 4'd3,
    DONE = 4'd4,
    ERR  = 4'd5
  } seq_state_t;

  // Bit positions inside the status word returned to the HPS.
  localparam int ST_DONE      = 0;
  localparam int ST_ERR       = 1;
  localparam int ST_LAYER_LSB = 2;

endpackage

// File: rtl/nn_done_collector.sv
// Sticky per-unit done mask for one layer; all_done also counts this cycle's done bits.
module nn_done_collector #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] done,
  output logic [W-1:0] mask,
  output logic         all_done
);

  logic [W-1:0] r_mask;
  logic [W-1:0] w_done;

  // Inactive layers must not leak done activity into their mask or completion.
  assign w_done = enable ? done : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_mask <= '0;
    else if (clear)  r_mask <= '0;
    else if (enable) r_mask <= r_mask | w_done;
  end

  assign mask     = r_mask;
  assign all_done = &(r_mask | w_done);

endmodule

// File: rtl/nn_layer_sequencer.sv
// Runs layer1 -> layer2 -> layer3 on an HPS start edge, with per-layer timeout and status word.
module nn_layer_sequencer #(
  parameter int          NUM_UNITS      = 7,
  parameter int          STATE_W        = nn_seq_pkg::STATE_W,
  parameter int          TIMEOUT_W      = 24,
  parameter int unsigned TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ready_from_hps,
  output logic [NUM_UNITS-1:0] done_to_hps,
  output logic                 l1_ready,
  input  logic [NUM_UNITS-1:0] l1_done,
  output logic [NUM_UNITS-1:0] l2_ready,
  input  logic [NUM_UNITS-1:0] l2_done,
  output logic [NUM_UNITS-1:0] l3_ready,
  input  logic                 l3_done,
  output logic [STATE_W-1:0]   state,
  output logic                 busy
);

  import nn_seq_pkg::*;

  localparam logic                 TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  if (longint'(TIMEOUT_CYCLES) >= (longint'(1) << TIMEOUT_W)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES does not fit in TIMEOUT_W bits");
  end
  if (NUM_UNITS < 4) begin : g_bad_units
    $error("NUM_UNITS must be at least 4 to hold the status word");
  end

  seq_state_t             r_state;
  seq_state_t             w_next;
  logic                   r_hps_q;
  logic [TIMEOUT_W-1:0]   r_cnt;
  logic [NUM_UNITS-1:0]   r_status;
  logic [NUM_UNITS-1:0]   w_status_next;
  logic                   r_l1_ready;
  logic [NUM_UNITS-1:0]   r_l2_ready;
  logic [NUM_UNITS-1:0]   r_l3_ready;
  logic                   r_busy;

  logic                   w_start;
  logic                   w_in_l1;
  logic                   w_in_l2;
  logic                   w_in_l3;
  logic                   w_in_layer;
  logic                   w_tmo;
  logic                   w_l1_all;
  logic                   w_l2_all;
  logic                   w_l3_all;
  logic [NUM_UNITS-1:0]   w_l1_mask;
  logic [NUM_UNITS-1:0]   w_l2_mask;
  logic [0:0]             w_l3_mask;
  logic                   w_unused_masks;

  assign w_start    = ready_from_hps & ~r_hps_q;
  assign w_in_l1    = (r_state == L1);
  assign w_in_l2    = (r_state == L2);
  assign w_in_l3    = (r_state == L3);
  assign w_in_layer = w_in_l1 | w_in_l2 | w_in_l3;
  assign w_tmo      = TMO_EN && (r_cnt == TMO_LAST);

  // Each collector is held clear outside its own layer, so every entry starts from an empty mask.
  nn_done_collector #(.W(NUM_UNITS)) u_l1_col (
    .clk(clk), .reset_n(reset_n), .clear(~w_in_l1), .enable(w_in_l1),
    .done(l1_done), .mask(w_l1_mask), .all_done(w_l1_all)
  );
  nn_done_collector #(.W(NUM_UNITS)) u_l2_col (
    .clk(clk), .reset_n(reset_n), .clear(~w_in_l2), .enable(w_in_l2),
    .done(l2_done), .mask(w_l2_mask), .all_done(w_l2_all)
  );
  nn_done_collector #(.W(1)) u_l3_col (
    .clk(clk), .reset_n(reset_n), .clear(~w_in_l3), .enable(w_in_l3),
    .done(l3_done), .mask(w_l3_mask), .all_done(w_l3_all)
  );

  assign w_unused_masks = ^{w_l1_mask, w_l2_mask, w_l3_mask};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Completion is tested before timeout so a layer finishing on its last allowed cycle advances.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_start) w_next = L1;
      L1: begin
        if (w_l1_all)   w_next = L2;
        else if (w_tmo) w_next = ERR;
      end
      L2: begin
        if (w_l2_all)   w_next = L3;
        else if (w_tmo) w_next = ERR;
      end
      L3: begin
        if (w_l3_all)   w_next = DONE;
        else if (w_tmo) w_next = ERR;
      end
      DONE, ERR: if (!ready_from_hps) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_status_next = r_status;
    if (w_next != r_state) begin
      case (w_next)
        IDLE: w_status_next = '0;
        DONE: w_status_next[ST_DONE] = 1'b1;
        ERR: begin
          w_status_next[ST_ERR] = 1'b1;
          w_status_next[ST_LAYER_LSB +: 2] = r_state[1:0];
        end
        default: ;
      endcase
    end
  end

  // Edge register comes out of reset high so a level held across reset is not a start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_hps_q <= 1'b1;
    else          r_hps_q <= ready_from_hps;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              r_cnt <= '0;
    else if ((w_next != r_state) || !w_in_layer) r_cnt <= '0;
    else                                       r_cnt <= r_cnt + 1'b1;
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_status   <= '0;
      r_l1_ready <= 1'b0;
      r_l2_ready <= '0;
      r_l3_ready <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_status   <= w_status_next;
      r_l1_ready <= (w_next == L1);
      r_l2_ready <= {NUM_UNITS{w_next == L2}};
      r_l3_ready <= {NUM_UNITS{w_next == L3}};
      r_busy     <= (w_next == L1) || (w_next == L2) || (w_next == L3);
    end
  end

  assign done_to_hps = r_status;
  assign l1_ready    = r_l1_ready;
  assign l2_ready    = r_l2_ready;
  assign l3_ready    = r_l3_ready;
  assign busy        = r_busy;
  assign state       = STATE_W'(r_state);

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer with TIMEOUT_CYCLES=100.
module tb_nn_layer_sequencer;

  localparam int NU = 7;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ready_from_hps;
  logic [NU-1:0] done_to_hps;
  logic          l1_ready;
  logic [NU-1:0] l1_done;
  logic [NU-1:0] l2_ready;
  logic [NU-1:0] l2_done;
  logic [NU-1:0] l3_ready;
  logic          l3_done;
  logic [3:0]    state;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  nn_layer_sequencer #(
    .NUM_UNITS(NU), .STATE_W(4), .TIMEOUT_W(24), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ready_from_hps(ready_from_hps),
    .done_to_hps(done_to_hps), .l1_ready(l1_ready), .l1_done(l1_done),
    .l2_ready(l2_ready), .l2_done(l2_done), .l3_ready(l3_ready),
    .l3_done(l3_done), .state(state), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // state, status, l1_ready, l2_ready, l3_ready, busy
  task automatic chk_all(string tag, int st, int stat, int r1, int r2, int r3, int b);
    chk({tag, ".state"},  32'(state),       32'(st));
    chk({tag, ".status"}, 32'(done_to_hps), 32'(stat));
    chk({tag, ".l1rdy"},  32'(l1_ready),    32'(r1));
    chk({tag, ".l2rdy"},  32'(l2_ready),    32'(r2));
    chk({tag, ".l3rdy"},  32'(l3_ready),    32'(r3));
    chk({tag, ".busy"},   32'(busy),        32'(b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with HPS request already high; no run may start afterwards.
    reset_n = 1'b0; ready_from_hps = 1'b1;
    l1_done = '0; l2_done = '0; l3_done = 1'b0;
    tick(2);
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick(4);
    chk_all("held_high", 0, 0, 0, 0, 0, 0);

    // Nominal run, dones 5 cycles after each ready rises.
    ready_from_hps = 1'b0; tick();
    ready_from_hps = 1'b1; tick();
    chk_all("nom_l1", 1, 0, 1, 0, 0, 1);
    tick(4);
    chk("nom_l1_hold", 32'(state), 32'd1);
    l1_done = 7'h7F; tick();
    chk_all("nom_l2", 2, 0, 0, 7'h7F, 0, 1);
    l1_done = '0;
    tick(4);
    chk("nom_l2_hold", 32'(state), 32'd2);
    l2_done = 7'h7F; tick();
    chk_all("nom_l3", 3, 0, 0, 0, 7'h7F, 1);
    l2_done = '0;
    tick(4);
    chk("nom_l3_hold", 32'(state), 32'd3);
    l3_done = 1'b1; tick();
    chk_all("nom_done", 4, 7'h01, 0, 0, 0, 0);
    l3_done = 1'b0;
    tick();
    chk("nom_done_hold", 32'(state), 32'd4);
    ready_from_hps = 1'b0; tick();
    chk_all("nom_idle", 0, 0, 0, 0, 0, 0);

    // L2/L3 activity during L1 is ignored; then staggered L2 pulses.
    ready_from_hps = 1'b1; tick();
    chk("stag_l1", 32'(state), 32'd1);
    l2_done = 7'h7F; l3_done = 1'b1; tick(3);
    chk("stag_l1_ignore", 32'(state), 32'd1);
    l1_done = 7'h7F; l2_done = '0; l3_done = 1'b0; tick();
    chk("stag_l2_entry", 32'(state), 32'd2);
    l1_done = '0; tick();
    chk("stag_l2_noleak", 32'(state), 32'd2);
    l2_done = 7'h01; tick();
    chk("stag_p01", 32'(state), 32'd2);
    l2_done = '0; tick();
    l2_done = 7'h06; tick();
    chk("stag_p06", 32'(state), 32'd2);
    l2_done = '0; tick();
    chk("stag_gap", 32'(state), 32'd2);
    l2_done = 7'h78; tick();
    chk_all("stag_l3", 3, 0, 0, 0, 7'h7F, 1);
    l2_done = '0;

    // Asynchronous reset mid-L3, request held high across it.
    tick();
    reset_n = 1'b0; #1;
    chk_all("rst_mid", 0, 0, 0, 0, 0, 0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk_all("rst_no_start", 0, 0, 0, 0, 0, 0);

    // Timeout in L2 with l2_done stuck at 0x3F.
    ready_from_hps = 1'b0; tick();
    ready_from_hps = 1'b1; l1_done = 7'h7F; tick();
    chk("tmo_l1", 32'(state), 32'd1);
    tick();
    chk("tmo_l2_entry", 32'(state), 32'd2);
    l1_done = '0; l2_done = 7'h3F;
    tick(99);
    chk("tmo_l2_last", 32'(state), 32'd2);
    tick();
    chk_all("tmo_err", 5, 7'h0A, 0, 0, 0, 0);
    tick(2);
    chk_all("tmo_err_hold", 5, 7'h0A, 0, 0, 0, 0);
    l2_done = '0; ready_from_hps = 1'b0; tick();
    chk_all("tmo_idle", 0, 0, 0, 0, 0, 0);

    // Final L1 bit on the cycle the counter reaches 99: completion wins.
    ready_from_hps = 1'b1; tick();
    chk("sim_l1", 32'(state), 32'd1);
    l1_done = 7'h3F;
    tick(99);
    chk("sim_l1_last", 32'(state), 32'd1);
    l1_done = 7'h40; tick();
    chk_all("sim_l2", 2, 0, 0, 7'h7F, 0, 1);
    l1_done = '0; l2_done = 7'h7F; tick();
    l2_done = '0; l3_done = 1'b1; tick();
    chk_all("sim_done", 4, 7'h01, 0, 0, 0, 0);
    l3_done = 1'b0; ready_from_hps = 1'b0; tick();
    chk("sim_idle", 32'(state), 32'd0);

    // Minimum-length run with every done already high.
    l1_done = 7'h7F; l2_done = 7'h7F; l3_done = 1'b1;
    ready_from_hps = 1'b1; tick();
    chk("min_l1", 32'(state), 32'd1);
    tick();
    chk("min_l2", 32'(state), 32'd2);
    tick();
    chk("min_l3", 32'(state), 32'd3);
    tick();
    chk_all("min_done", 4, 7'h01, 0, 0, 0, 0);
    ready_from_hps = 1'b0; tick();
    chk_all("min_idle", 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Sequences the three fabric neural-network layers for one inference. It starts on a request from the HPS, raises each layer's ready lines in order, and collects per-unit done bits into sticky masks. A layer timeout aborts the run, and a status word goes back to the HPS. It sits between the HPS ready/done PIO exports and the layer1/2/3 control conduits.

## Interface
- NUM_UNITS, 7: parallel neuron units per layer; width of multi-bit ready/done lines.
- STATE_W, 4: width of the state output.
- TIMEOUT_W, 24: width of the per-layer cycle counter.
- TIMEOUT_CYCLES, 24'd10_000_000: cycles allowed per layer; 0 disables the timeout.

Ports:
- clk  in  1  system clock (65 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- ready_from_hps  in  1  HPS start request, level.
- done_to_hps  out  NUM_UNITS  status word:
  - bit0 = run complete.
  - bit1 = timeout error.
  - bits[3:2] = layer at error (1..3).
  - others 0.
- l1_ready  out  1  layer1 start/hold.
- l1_done  in  NUM_UNITS  layer1 per-unit done.
- l2_ready  out  NUM_UNITS  layer2 per-unit start/hold.
- l2_done  in  NUM_UNITS  layer2 per-unit done.
- l3_ready  out  NUM_UNITS  layer3 per-unit start/hold.
- l3_done  in  1  layer3 done.
- state  out  STATE_W  current FSM state.
- busy  out  1  high in L1, L2 or L3.

## Operation
- States and encodings: IDLE=0, L1=1, L2=2, L3=3, DONE=4, ERR=5. Codes 6..15 are illegal and go to IDLE next cycle.
- Start condition: rising edge of ready_from_hps.
  - Edge register resets to 1, so a level already high out of reset does not start a run.
  - Only an edge seen in IDLE starts a run; edges in other states are ignored.
- IDLE -> L1 on a start edge.
- Ready outputs are level and stay high for the whole of their state:
  - L1: l1_ready=1.
  - L2: l2_ready=all ones.
  - L3: l3_ready=all ones.
  - All ready outputs are 0 in every other state.
- Done collection:
  - In layer state Lk, done_mask_k |= lk_done each cycle.
  - The layer is complete when (done_mask_k | lk_done) == all ones. Done bits arriving this cycle count.
- Transitions on completion: L1 -> L2, L2 -> L3, L3 -> DONE. The mask and timeout counter clear on every layer entry.
- Done inputs of layers not currently active are ignored.
- Timeout: in Lk, if the layer is not complete and the counter == TIMEOUT_CYCLES-1, go to ERR. Set done_to_hps[1]=1 and bits[3:2]=k.
- Simultaneous completion and timeout expiry: completion wins.
- DONE: done_to_hps[0]=1. Hold until ready_from_hps==0, then go to IDLE.
- ERR: status held until ready_from_hps==0, then go to IDLE. The status word clears on IDLE entry.
- Reset, including mid-run:
  - All outputs 0 and state=IDLE.
  - Masks and counter cleared.
  - Edge register set to 1.

## Timing
- Start edge sampled in cycle N; state=L1 and l1_ready=1 from cycle N+1.
- All dones present in cycle M of Lk: next state from cycle M+1. The old ready drops and the new ready rises on the same edge.
- Minimum run length: 3 cycles when every layer's done lines are already high.
- Timeout fires after exactly TIMEOUT_CYCLES cycles in a layer; ERR is visible on the following cycle.
- DONE/ERR -> IDLE one cycle after ready_from_hps samples 0.
- All outputs are registered; no combinational input-to-output paths.
- Counter width rule: TIMEOUT_CYCLES must be < 2**TIMEOUT_W; elaboration asserts this.

## Structure
- Shared package nn_seq_pkg holds:
  - state enum seq_state_t with the encodings above;
  - STATE_W;
  - status bit index constants (ST_DONE=0, ST_ERR=1, ST_LAYER_LSB=2).
- Sub-module nn_done_collector (parameter W):
  - inputs: clk, reset_n, clear, enable, done[W-1:0];
  - outputs: mask, all_done (combinational including the current input).
  - Instantiated for L1 and L2 at W=NUM_UNITS and for L3 at W=1.
- Top module: FSM, edge detector, timeout counter, status register.

## Test plan
- Nominal run, TIMEOUT_CYCLES=100:
  - Stimulus: ready_from_hps 0->1; each layer's done=all ones 5 cycles after its ready rises.
  - Required: state 1,2,3,4; done_to_hps=7'h01; after ready_from_hps=0, state=0 and done_to_hps=0.
- Staggered done pulses in L2:
  - Stimulus: 1-cycle l2_done pulses 0x01, 0x06, 0x78 on separate cycles.
  - Required: stays in L2 until the 0x78 cycle, then L3 on the next cycle.
- Timeout in L2:
  - Stimulus: TIMEOUT_CYCLES=100, l2_done stuck at 0x3F.
  - Required: ERR exactly 100 cycles after L2 entry; done_to_hps=7'h0A; all readies 0.
- Simultaneous events:
  - Final l1_done bit arrives in the cycle the counter hits 99: next state is L2, not ERR.
  - l2_done/l3_done activity during L1 does not advance L2 or L3.
- Reset behaviour:
  - reset_n pulsed low mid-L3: outputs 0 and state=IDLE immediately.
  - Reset released with ready_from_hps held 1: no run starts until a 0->1 edge.
